clock_phase_gen: RTL

- Generates the four derived clocks that drive the processor skeleton from the single board clock: imem_clock, dmem_clock, processor_clock and regfile_clock.
- One processor cycle is PHASES ticks of clock. Each derived clock follows a per-phase level pattern set by a parameter.
- Sits directly upstream of the skeleton.
- Adds run/halt and single-step control for debug, plus a retired-cycle counter.

---
 rtl/clock_phase_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/clock_phase_gen.sv
// rtl/clock_phase_gen.sv - derives the four skeleton clocks from the board clock
// Phase counter with run/halt/single-step control; every output comes straight from a register.
module clock_phase_gen #(
  parameter int               PHASES   = 6,
  parameter int               PHASE_W  = 4,
  parameter logic [PHASES-1:0] IMEM_PAT = 6'b011111,
  parameter logic [PHASES-1:0] DMEM_PAT = 6'b011000,
  parameter logic [PHASES-1:0] PROC_PAT = 6'b000111,
  parameter logic [PHASES-1:0] RF_PAT   = 6'b000110
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  output logic               imem_clock,
  output logic               dmem_clock,
  output logic               processor_clock,
  output logic               regfile_clock,
  output logic [PHASE_W-1:0] phase,
  output logic               cycle_start,
  output logic               halted,
  output logic [31:0]        cycle_count
);

  // Patterns widened to the full phase-index range so indexing by phase is width-exact.
  localparam int PW = 1 << PHASE_W;
  localparam logic [PW-1:0] IMEM_X = PW'(IMEM_PAT);
  localparam logic [PW-1:0] DMEM_X = PW'(DMEM_PAT);
  localparam logic [PW-1:0] PROC_X = PW'(PROC_PAT);
  localparam logic [PW-1:0] RF_X   = PW'(RF_PAT);
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(PHASES - 1);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [31:0]        cycle_count_q, cycle_count_d;
  logic               cycle_start_q, cycle_start_d;
  logic               halted_q;
  logic               imem_q, dmem_q, proc_q, rf_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cycle_count_d = cycle_count_q;
    cycle_start_d = 1'b0;
    case (state_q)
      S_HALT: begin
        phase_d = '0;
        if (run) begin
          state_d = S_RUN;
          phase_d = PHASE_W'(1);
        end else if (step) begin
          state_d = S_STEP;
          phase_d = PHASE_W'(1);
        end
      end
      default: begin
        // run is only looked at on the wrap, so an in-flight cycle always finishes.
        if (phase_q == LAST) begin
          phase_d       = '0;
          cycle_count_d = cycle_count_q + 32'd1;
          cycle_start_d = 1'b1;
          state_d       = (state_q == S_RUN && run) ? S_RUN : S_HALT;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_HALT;
      phase_q       <= '0;
      cycle_count_q <= '0;
      cycle_start_q <= 1'b0;
      halted_q      <= 1'b1;
      imem_q        <= IMEM_X[0];
      dmem_q        <= DMEM_X[0];
      proc_q        <= PROC_X[0];
      rf_q          <= RF_X[0];
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cycle_count_q <= cycle_count_d;
      cycle_start_q <= cycle_start_d;
      halted_q      <= (state_d == S_HALT);
      imem_q        <= IMEM_X[phase_d];
      dmem_q        <= DMEM_X[phase_d];
      proc_q        <= PROC_X[phase_d];
      rf_q          <= RF_X[phase_d];
    end
  end

  assign imem_clock      = imem_q;
  assign dmem_clock      = dmem_q;
  assign processor_clock = proc_q;
  assign regfile_clock   = rf_q;
  assign phase           = phase_q;
  assign cycle_start     = cycle_start_q;
  assign halted          = halted_q;
  assign cycle_count     = cycle_count_q;

endmodule
